// File: rtl/alu_exec.sv
// alu_exec: execution stage that follows the ALU control decode.
//
// Takes the decoded operand alu_a, the top-of-stack operand alu_b, the carry-in
// alu_ic and a 3-bit opcode. It computes the result and holds the architectural
// carry flag. The result is returned through a valid/ready handshake.
//
// Opcode encoding (OP_*): ADD=0, AND=1, OR=2, LSL=3, LSR=4, ASR=5, CSL=6, CSR=7.
// All eight codes are used. The case default falls through to OR.
//
// Compile-time option ALU_BARREL_SHIFT_EN:
//   defined   - every shift completes in one cycle, SHIFT is never entered and
//               busy is tied low.
//   undefined - shifts run one bit per cycle through a 2W {hi,lo} register.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   in_valid / in_ready    input handshake (in_ready is combinational on out_ready)
//   alu_a, alu_b           operands (alu_b low log2(W) bits = shift amount)
//   alu_ic                 carry-in, used by ADD only
//   alu_opcode             OP_* encoding
//   out_valid / out_ready  output handshake
//   out_result             registered result
//   carry                  registered carry flag, fed back to decode
//   busy                   high while an iterative shift is running
//
// state  | meaning
// -------+-------------------------------
// IDLE   | no result held
// SHIFT  | iterative shift in progress
// DONE   | result held in out_result

module alu_exec #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] alu_a,
    input  logic [WORD_WIDTH-1:0] alu_b,
    input  logic                  alu_ic,
    input  logic [2:0]            alu_opcode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_result,
    output logic                  carry,
    output logic                  busy
);

    localparam int W  = WORD_WIDTH;
    localparam int LW = $clog2(WORD_WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_LSL = 3'd3;
    localparam logic [2:0] OP_LSR = 3'd4;
    localparam logic [2:0] OP_ASR = 3'd5;
    localparam logic [2:0] OP_CSL = 3'd6;
    localparam logic [2:0] OP_CSR = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_result;
    logic           r_carry;

    logic           w_accept;
    logic           w_is_shift;
    logic [LW-1:0]  w_k;
    logic [W:0]     w_sum;
    logic [W-1:0]   w_alu_res;

    assign in_ready   = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == S_DONE);
    assign out_result = r_result;
    assign carry      = r_carry;

    // Upper bits of alu_b are deliberately ignored for shifts.
    assign w_k = alu_b[LW-1:0];

    assign w_is_shift = (alu_opcode == OP_LSL) || (alu_opcode == OP_LSR) ||
                        (alu_opcode == OP_ASR) || (alu_opcode == OP_CSL) ||
                        (alu_opcode == OP_CSR);

    // Full W+1 bit add so the carry-out comes straight from the top bit.
    assign w_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_ic};

    always_comb begin
        w_alu_res = alu_a | alu_b;
        case (alu_opcode)
            OP_ADD:  w_alu_res = w_sum[W-1:0];
            OP_AND:  w_alu_res = alu_a & alu_b;
            default: w_alu_res = alu_a | alu_b;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    // One-cycle equivalents of the iterative {hi,lo} shifts.
    logic [2*W-1:0] w_bar_left;
    logic [2*W-1:0] w_bar_right;
    logic [2*W-1:0] w_bar_arith;
    logic [W-1:0]   w_bar_res;

    assign w_bar_left  = {{W{1'b0}}, alu_a} << w_k;
    assign w_bar_right = {alu_a, {W{1'b0}}} >> w_k;
    assign w_bar_arith = $signed({alu_a, {W{1'b0}}}) >>> w_k;

    always_comb begin
        w_bar_res = w_bar_left[W-1:0];
        case (alu_opcode)
            OP_LSL:  w_bar_res = w_bar_left[W-1:0];
            OP_CSL:  w_bar_res = w_bar_left[2*W-1:W];
            OP_LSR:  w_bar_res = w_bar_right[2*W-1:W];
            OP_CSR:  w_bar_res = w_bar_right[W-1:0];
            default: w_bar_res = w_bar_arith[2*W-1:W];
        endcase
    end

    assign busy = 1'b0;
`else
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic [LW-1:0]  r_cnt;
    logic [2:0]     r_op;
    logic           r_fill;

    logic           w_load_left;
    logic [W-1:0]   w_k0_res;
    logic           w_run_left;
    logic [2*W-1:0] w_cat;
    logic [2*W-1:0] w_step;
    logic [W-1:0]   w_step_res;

    assign w_load_left = (alu_opcode == OP_LSL) || (alu_opcode == OP_CSL);

    // With a zero amount nothing is shifted out, so the carry-out variants give 0.
    assign w_k0_res = ((alu_opcode == OP_CSL) || (alu_opcode == OP_CSR)) ? '0 : alu_a;

    assign w_run_left = (r_op == OP_LSL) || (r_op == OP_CSL);
    assign w_cat      = {r_hi, r_lo};
    // r_fill is the sign bit for ASR and 0 for the logical/carry right shifts.
    assign w_step     = w_run_left ? {w_cat[2*W-2:0], 1'b0} : {r_fill, w_cat[2*W-1:1]};

    // Result taken from the value after the final shift step.
    always_comb begin
        w_step_res = w_step[2*W-1:W];
        case (r_op)
            OP_LSL:  w_step_res = w_step[W-1:0];
            OP_CSL:  w_step_res = w_step[2*W-1:W];
            OP_CSR:  w_step_res = w_step[W-1:0];
            default: w_step_res = w_step[2*W-1:W];
        endcase
    end

    assign busy = (r_state == S_SHIFT);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_carry  <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_op     <= OP_ADD;
            r_fill   <= 1'b0;
`endif
        end else if (w_accept) begin
            if (w_is_shift) begin
`ifdef ALU_BARREL_SHIFT_EN
                r_result <= w_bar_res;
                r_state  <= S_DONE;
`else
                if (w_k == '0) begin
                    r_result <= w_k0_res;
                    r_state  <= S_DONE;
                end else begin
                    r_hi    <= w_load_left ? '0 : alu_a;
                    r_lo    <= w_load_left ? alu_a : '0;
                    r_cnt   <= w_k;
                    r_op    <= alu_opcode;
                    r_fill  <= (alu_opcode == OP_ASR) && alu_a[W-1];
                    r_state <= S_SHIFT;
                end
`endif
            end else begin
                r_result <= w_alu_res;
                r_state  <= S_DONE;
                if (alu_opcode == OP_ADD) begin
                    r_carry <= w_sum[W];
                end
            end
        end else begin
            case (r_state)
                S_SHIFT: begin
`ifdef ALU_BARREL_SHIFT_EN
                    r_state <= S_IDLE;
`else
                    r_hi <= w_step[2*W-1:W];
                    r_lo <= w_step[W-1:0];
                    if (r_cnt == LW'(1)) begin
                        r_result <= w_step_res;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - LW'(1);
                    end
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_LSL = 3'd3;
    localparam logic [2:0] OP_LSR = 3'd4;
    localparam logic [2:0] OP_ASR = 3'd5;
    localparam logic [2:0] OP_CSL = 3'd6;
    localparam logic [2:0] OP_CSR = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_ic;
    logic [2:0]  alu_opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        carry;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    alu_exec #(.WORD_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ic     (alu_ic),
        .alu_opcode (alu_opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .carry      (carry),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ic);
        in_valid   = 1'b1;
        alu_opcode = op;
        alu_a      = a;
        alu_b      = b;
        alu_ic     = ic;
    endtask

    // Accepts one shift, counts busy cycles (bounded), checks latency and result,
    // then lets the result drain with out_ready high.
    task automatic run_shift(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int k, input logic [31:0] exp,
                             input logic exp_carry);
        int n;
        int exp_busy;
`ifdef ALU_BARREL_SHIFT_EN
        exp_busy = 0;
`else
        exp_busy = k;
`endif
        drive(op, a, b, 1'b0);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            chk({tag, "_no_valid_while_busy"}, {31'b0, out_valid}, 32'd0);
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, n, exp_busy);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_result"}, out_result, exp);
        chk({tag, "_carry"}, {31'b0, carry}, {31'b0, exp_carry});
        tick();
        chk({tag, "_drained"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        alu_a      = '0;
        alu_b      = '0;
        alu_ic     = 1'b0;
        alu_opcode = OP_ADD;
        tick();
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_carry", {31'b0, carry}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        reset = 1'b0;
        tick();

        // Carry chain, back to back
        drive(OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
        tick();
        chk("add1_valid", {31'b0, out_valid}, 32'd1);
        chk("add1_result", out_result, 32'h0000_0000);
        chk("add1_carry", {31'b0, carry}, 32'd1);
        chk("add1_in_ready", {31'b0, in_ready}, 32'd1);
        drive(OP_ADD, 32'd0, 32'd0, carry);
        tick();
        chk("add2_valid", {31'b0, out_valid}, 32'd1);
        chk("add2_result", out_result, 32'h0000_0001);
        chk("add2_carry", {31'b0, carry}, 32'd0);
        drive(OP_OR, 32'h0000_00F0, 32'h0000_0F00, 1'b0);
        tick();
        chk("or_result", out_result, 32'h0000_0FF0);
        chk("or_carry_kept", {31'b0, carry}, 32'd0);
        in_valid = 1'b0;
        tick();
        chk("idle_after_drain", {31'b0, out_valid}, 32'd0);

        // Set carry so the shifts can show it is left alone
        drive(OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b1);
        tick();
        chk("add3_result", out_result, 32'h0000_0001);
        chk("add3_carry", {31'b0, carry}, 32'd1);
        in_valid = 1'b0;
        tick();

        run_shift("lsl4",  OP_LSL, 32'h8000_0001, 32'd4,  4,  32'h0000_0010, 1'b1);
        run_shift("csl4",  OP_CSL, 32'h8000_0001, 32'd4,  4,  32'h0000_0008, 1'b1);
        run_shift("asr31", OP_ASR, 32'h8000_0000, 32'd31, 31, 32'hFFFF_FFFF, 1'b1);
        run_shift("lsr31", OP_LSR, 32'h8000_0000, 32'd31, 31, 32'h0000_0001, 1'b1);
        run_shift("csr4",  OP_CSR, 32'h0000_000F, 32'd4,  4,  32'hF000_0000, 1'b1);
        run_shift("lsl_k0", OP_LSL, 32'h0000_1234, 32'h20, 0, 32'h0000_1234, 1'b1);
        run_shift("csl_k0", OP_CSL, 32'h0000_1234, 32'h20, 0, 32'h0000_0000, 1'b1);
        run_shift("asr_k1", OP_ASR, 32'h4000_0000, 32'hFFFF_FFE1, 1, 32'h2000_0000, 1'b1);

        // Backpressure
        out_ready = 1'b0;
        drive(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
        tick();
        drive(OP_OR, 32'h0000_0F00, 32'h0000_00F0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result", out_result, 32'h0000_F000);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_up", {31'b0, in_ready}, 32'd1);
        tick();
        chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_next_result", out_result, 32'h0000_0FF0);
        in_valid = 1'b0;
        tick();

        // Reset during a k=10 shift
        drive(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        tick();
        chk("pre_rst_carry", {31'b0, carry}, 32'd1);
        drive(OP_LSL, 32'h0000_0001, 32'd10, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_carry", {31'b0, carry}, 32'd0);
        chk("mid_rst_result", out_result, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        reset = 1'b0;
        drive(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
        tick();
        chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("post_rst_result", out_result, 32'h0000_F000);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
